fifo_rd_serializer: RTL and testbench

Read-side consumer for the team's synchronous FIFO. It pops WIDTH-bit words through the FIFO read port (rd_en / rdata / empty) and shifts each word out one bit per accepted beat on a valid/ready serial stream. It marks the final bit of each word and keeps a count of completed words. It sits between a sync_fifo instance and a bit-serial sink, such as a line transmitter or shift-chain loader.

---
 rtl/fifo_rd_ser_pkg.sv | 18 +
 rtl/fifo_rd_serializer.sv | 137 +++++++++++++
 tb/tb_fifo_rd_serializer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ser_pkg.sv
// Shared definitions for the FIFO read-side serializer.
//   state_e         : FSM state encoding (IDLE, FETCH, LOAD, SHIFT)
//   bit_cnt_width() : width of the per-word bit counter for a given word width
package fifo_rd_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_e;

  // Bit counter must be able to index every bit of a word; never narrower than 1.
  function automatic int unsigned bit_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fifo_rd_serializer.sv
// Pops WIDTH-bit words from a synchronous FIFO read port and shifts them out
// one bit per accepted beat on a valid/ready serial stream.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   en_i                : permits new FIFO fetches (a word in flight always completes)
//   fifo_empty_i        : FIFO empty flag
//   fifo_rdata_i        : FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_rd_en_o        : one-cycle FIFO pop strobe
//   ser_data_o          : current serial bit
//   ser_valid_o         : ser_data_o is valid
//   ser_last_o          : current bit is the final bit of the word
//   ser_ready_i         : sink accepts the bit when valid and ready are both high
//   busy_o              : FSM is not IDLE
//   word_cnt_o          : completed-word counter, wraps silently
module fifo_rd_serializer
  import fifo_rd_ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 fifo_empty_i,
  input  logic [WIDTH-1:0]     fifo_rdata_i,
  output logic                 fifo_rd_en_o,
  output logic                 ser_data_o,
  output logic                 ser_valid_o,
  output logic                 ser_last_o,
  input  logic                 ser_ready_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o
);

  localparam int unsigned BCW = bit_cnt_width(WIDTH);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                 rd_en_q, rd_en_d;
  logic                 data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;

  logic                 fetch_ok_c;

  assign fetch_ok_c = en_i & ~fifo_empty_i;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;

    case (state_q)
      IDLE: begin
        if (fetch_ok_c) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d = fifo_rdata_i;
        bcnt_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (ser_ready_i) begin
          if (MSB_FIRST) begin
            shreg_d = shreg_q << 1;
          end else begin
            shreg_d = shreg_q >> 1;
          end
          bcnt_d = bcnt_q + BCW'(1);
          if (bcnt_q == LAST_IDX) begin
            wcnt_d  = wcnt_q + CNT_WIDTH'(1);
            // Chain straight into the next fetch to keep the bubble at 2 cycles.
            state_d = fetch_ok_c ? FETCH : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    rd_en_d = (state_d == FETCH);
    valid_d = (state_d == SHIFT);
    last_d  = valid_d && (bcnt_d == LAST_IDX);
    busy_d  = (state_d != IDLE);
    data_d  = 1'b0;
    if (valid_d) begin
      data_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      rd_en_q <= 1'b0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      rd_en_q <= rd_en_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign fifo_rd_en_o = rd_en_q;
  assign ser_data_o   = data_q;
  assign ser_valid_o  = valid_q;
  assign ser_last_o   = last_q;
  assign busy_o       = busy_q;
  assign word_cnt_o   = wcnt_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench for fifo_rd_serializer: an LSB-first instance fed by a small
// FIFO model, plus an MSB-first instance fed directly by the stimulus.
module tb_fifo_rd_serializer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        ser_ready_i = 1'b0;

  // LSB-first instance with FIFO model
  logic        empty_l;
  logic [3:0]  rdata_l;
  logic        rd_en_l, data_l, valid_l, last_l, busy_l;
  logic [15:0] wcnt_l;

  // MSB-first instance with directly driven FIFO port
  logic        empty_m = 1'b1;
  logic [3:0]  rdata_m = 4'h0;
  logic        rd_en_m, data_m, valid_m, last_m, busy_m;
  logic [15:0] wcnt_m;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fifo_rd_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .CNT_WIDTH(16)) dut_l (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .fifo_empty_i(empty_l), .fifo_rdata_i(rdata_l), .fifo_rd_en_o(rd_en_l),
    .ser_data_o(data_l), .ser_valid_o(valid_l), .ser_last_o(last_l),
    .ser_ready_i(ser_ready_i), .busy_o(busy_l), .word_cnt_o(wcnt_l)
  );

  fifo_rd_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) dut_m (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .fifo_empty_i(empty_m), .fifo_rdata_i(rdata_m), .fifo_rd_en_o(rd_en_m),
    .ser_data_o(data_m), .ser_valid_o(valid_m), .ser_last_o(last_m),
    .ser_ready_i(ser_ready_i), .busy_o(busy_m), .word_cnt_o(wcnt_m)
  );

  // FIFO model: read data appears the cycle after the pop strobe
  logic [3:0] mem [0:15];
  int wp = 0;
  int rp = 0;
  assign empty_l = (wp == rp);

  int pulses_l = 0;
  int dbl_l = 0;
  int underflow_l = 0;
  logic prev_rd_l = 1'b0;

  always @(posedge clk_i) begin
    if (rd_en_l === 1'b1) begin
      rdata_l  <= mem[rp[3:0]];
      rp       <= rp + 1;
      pulses_l <= pulses_l + 1;
      if (prev_rd_l) dbl_l <= dbl_l + 1;
      if (empty_l) underflow_l <= underflow_l + 1;
    end
    prev_rd_l <= (rd_en_l === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic push(input logic [3:0] w);
    mem[wp[3:0]] = w;
    wp = wp + 1;
  endtask

  // Bounded wait for a pop strobe on the selected instance
  task automatic wait_rd(input bit msb, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ((msb ? rd_en_m : rd_en_l) === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic chk_bit_l(input string tag, input logic d, input logic l);
    chk({tag, "_valid"}, 32'(valid_l), 32'd1);
    chk({tag, "_data"}, 32'(data_l), 32'(d));
    chk({tag, "_last"}, 32'(last_l), 32'(l));
  endtask

  initial begin
    logic [3:0] w;

    // Reset state
    step();
    step();
    chk("rst_rd_en", 32'(rd_en_l), 32'd0);
    chk("rst_data", 32'(data_l), 32'd0);
    chk("rst_valid", 32'(valid_l), 32'd0);
    chk("rst_last", 32'(last_l), 32'd0);
    chk("rst_busy", 32'(busy_l), 32'd0);
    chk("rst_wcnt", 32'(wcnt_l), 32'd0);
    chk("rst_m_valid", 32'(valid_m), 32'd0);
    chk("rst_m_wcnt", 32'(wcnt_m), 32'd0);
    rst_i = 1'b0;
    step();

    // Single word 0xA, LSB first
    push(4'hA);
    en_i = 1'b1;
    ser_ready_i = 1'b1;
    wait_rd(1'b0, "t1_rd_seen");
    step();
    chk("t1_gap_valid", 32'(valid_l), 32'd0);
    chk("t1_gap_rd_en", 32'(rd_en_l), 32'd0);
    chk("t1_gap_busy", 32'(busy_l), 32'd1);
    w = 4'hA;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_bit_l("t1_bit", w[i], i == 3);
    end
    step();
    chk("t1_end_valid", 32'(valid_l), 32'd0);
    chk("t1_end_last", 32'(last_l), 32'd0);
    chk("t1_end_busy", 32'(busy_l), 32'd0);
    chk("t1_wcnt", 32'(wcnt_l), 32'd1);
    chk("t1_pulses", 32'(pulses_l), 32'd1);

    // Single word 0xA, MSB first (LSB instance sees an empty FIFO)
    rdata_m = 4'hA;
    empty_m = 1'b0;
    wait_rd(1'b1, "t2_rd_seen");
    empty_m = 1'b1;
    step();
    chk("t2_gap_valid", 32'(valid_m), 32'd0);
    w = 4'hA;
    for (int i = 3; i >= 0; i--) begin
      step();
      chk("t2_valid", 32'(valid_m), 32'd1);
      chk("t2_data", 32'(data_m), 32'(w[i]));
      chk("t2_last", 32'(last_m), 32'(i == 0));
    end
    step();
    chk("t2_end_valid", 32'(valid_m), 32'd0);
    chk("t2_end_busy", 32'(busy_m), 32'd0);
    chk("t2_wcnt", 32'(wcnt_m), 32'd1);

    // Back-to-back words 0x3 then 0xC
    push(4'h3);
    push(4'hC);
    wait_rd(1'b0, "t3_rd_seen");
    step();
    chk("t3_rd_single", 32'(rd_en_l), 32'd0);
    w = 4'h3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_bit_l("t3_w0", w[i], i == 3);
    end
    step();
    chk("t3_rd2_at_m1", 32'(rd_en_l), 32'd1);
    chk("t3_bubble1_valid", 32'(valid_l), 32'd0);
    step();
    chk("t3_rd2_single", 32'(rd_en_l), 32'd0);
    chk("t3_bubble2_valid", 32'(valid_l), 32'd0);
    w = 4'hC;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_bit_l("t3_w1", w[i], i == 3);
    end
    step();
    chk("t3_end_valid", 32'(valid_l), 32'd0);
    chk("t3_wcnt", 32'(wcnt_l), 32'd3);
    chk("t3_pulses", 32'(pulses_l), 32'd3);

    // Word 0x5 with a 3-cycle stall on bit 1
    push(4'h5);
    wait_rd(1'b0, "t4_rd_seen");
    step();
    step();
    chk_bit_l("t4_b0", 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_bit_l("t4_b1_hold", 1'b0, 1'b0);
      if (k == 0) ser_ready_i = 1'b0;
      if (k == 3) ser_ready_i = 1'b1;
    end
    step();
    chk_bit_l("t4_b2", 1'b1, 1'b0);
    step();
    chk_bit_l("t4_b3", 1'b0, 1'b1);
    step();
    chk("t4_end_valid", 32'(valid_l), 32'd0);
    chk("t4_wcnt", 32'(wcnt_l), 32'd4);
    chk("t4_pulses", 32'(pulses_l), 32'd4);

    // Empty FIFO with enable held high
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_rd_en", 32'(rd_en_l), 32'd0);
      chk("t5_valid", 32'(valid_l), 32'd0);
      chk("t5_busy", 32'(busy_l), 32'd0);
    end

    // Reset mid-word on 0xF with 0x7 queued behind it
    push(4'hF);
    push(4'h7);
    wait_rd(1'b0, "t6_rd_seen");
    step();
    step();
    chk_bit_l("t6_b0", 1'b1, 1'b0);
    step();
    chk_bit_l("t6_b1", 1'b1, 1'b0);
    step();
    rst_i = 1'b1;
    step();
    chk("t6_rst_rd_en", 32'(rd_en_l), 32'd0);
    chk("t6_rst_data", 32'(data_l), 32'd0);
    chk("t6_rst_valid", 32'(valid_l), 32'd0);
    chk("t6_rst_last", 32'(last_l), 32'd0);
    chk("t6_rst_busy", 32'(busy_l), 32'd0);
    chk("t6_rst_wcnt", 32'(wcnt_l), 32'd0);
    rst_i = 1'b0;
    wait_rd(1'b0, "t6_rd2_seen");
    step();
    w = 4'h7;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_bit_l("t6_w1", w[i], i == 3);
    end
    step();
    chk("t6_end_valid", 32'(valid_l), 32'd0);
    chk("t6_wcnt", 32'(wcnt_l), 32'd1);
    chk("t6_pulses", 32'(pulses_l), 32'd6);

    // Global pop-strobe properties
    chk("rd_en_consecutive", 32'(dbl_l), 32'd0);
    chk("rd_en_while_empty", 32'(underflow_l), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
